seq_calc_unit: RTL

//  Parametrised, handshaked arithmetic unit: the multi-cycle successor of the

---
 rtl/seq_calc_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/seq_calc_unit.sv
// Handshaked four-function arithmetic unit: add/sub finish in one cycle,
// mul (shift-add, LSB first) and div (restoring, MSB first) iterate WIDTH cycles.
module seq_calc_unit #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               dbz
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // a result transfers on a rising edge where out_valid && out_ready. Neither
  // ready depends combinationally on the matching valid.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opnd_q;  // multiplicand for mul, divisor for div
  logic [WIDTH-1:0] hi_q;    // partial product high half / partial remainder
  logic [WIDTH-1:0] lo_q;    // multiplier being shifted out / quotient shifting in

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic [WIDTH:0]   mul_acc;
  logic [WIDTH-1:0] mul_hi_nxt;
  logic [WIDTH-1:0] mul_lo_nxt;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             div_ok;
  logic [WIDTH-1:0] div_hi_nxt;
  logic [WIDTH-1:0] div_lo_nxt;
  logic             last_iter;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  assign add_sum  = {1'b0, a} + {1'b0, b};
  assign sub_diff = {1'b0, a} - {1'b0, b};

  // Shift-add step: conditionally add the multiplicand, then shift the
  // {carry, hi, lo} chain right so the next multiplier bit reaches lo_q[0].
  assign mul_acc    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign mul_hi_nxt = mul_acc[WIDTH:1];
  assign mul_lo_nxt = {mul_acc[0], lo_q[WIDTH-1:1]};

  // Restoring step: the remainder is always below the divisor, so the shifted
  // value fits WIDTH+1 bits and the trial's top bit is the borrow.
  assign div_shift  = {hi_q, lo_q[WIDTH-1]};
  assign div_trial  = div_shift - {1'b0, opnd_q};
  assign div_ok     = ~div_trial[WIDTH];
  assign div_hi_nxt = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_lo_nxt = {lo_q[WIDTH-2:0], div_ok};

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      result <= '0;
      carry  <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            dbz <= 1'b0;
            case (op)
              2'd0: begin
                result <= {{(WIDTH-1){1'b0}}, add_sum};
                carry  <= add_sum[WIDTH];
                state  <= S_DONE;
              end
              2'd1: begin
                result <= {{WIDTH{sub_diff[WIDTH]}}, sub_diff[WIDTH-1:0]};
                carry  <= sub_diff[WIDTH];
                state  <= S_DONE;
              end
              2'd2: begin
                carry  <= 1'b0;
                opnd_q <= a;
                hi_q   <= '0;
                lo_q   <= b;
                cnt    <= '0;
                state  <= S_MUL;
              end
              default: begin
                carry <= 1'b0;
                if (b == '0) begin
                  result <= {a, {WIDTH{1'b1}}};
                  dbz    <= 1'b1;
                  state  <= S_DONE;
                end else begin
                  opnd_q <= b;
                  hi_q   <= '0;
                  lo_q   <= a;
                  cnt    <= '0;
                  state  <= S_DIV;
                end
              end
            endcase
          end
        end
        S_MUL: begin
          hi_q <= mul_hi_nxt;
          lo_q <= mul_lo_nxt;
          cnt  <= cnt + 1'b1;
          if (last_iter) begin
            result <= {mul_hi_nxt, mul_lo_nxt};
            state  <= S_DONE;
          end
        end
        S_DIV: begin
          hi_q <= div_hi_nxt;
          lo_q <= div_lo_nxt;
          cnt  <= cnt + 1'b1;
          if (last_iter) begin
            result <= {div_hi_nxt, div_lo_nxt};
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
